// File: rtl/fdiv_arb_pkg.sv
// fdiv_arb_pkg: shared types and default sizing for the fdiv sharing arbiter.
// shadow_t matches the default configuration; other sizes build their own slot type.
package fdiv_arb_pkg;

  localparam int NREQ_DEF = 2;
  localparam int LAT_DEF  = 4;
  localparam int TAGW_DEF = 5;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    logic                        v;
    logic [$clog2(NREQ_DEF)-1:0] id;
    logic [TAGW_DEF-1:0]         tag;
  } shadow_t;

endpackage

// File: rtl/fdiv_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible
// requester at or after ptr, wrapping; one-hot grant plus encoded id.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);

  logic [IDW-1:0] idx;

  // walk backwards so the closest candidate to ptr is written last
  always_comb begin
    grant = '0;
    id    = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/fdiv_share_arb.sv
// fdiv_share_arb: shares one pipelined fdiv among NREQ requesters;
// a shadow pipe carries id/tag so each result returns to its owner.
module fdiv_share_arb
  import fdiv_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LAT  = LAT_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x1,
  input  logic [NREQ*32-1:0]   req_x2,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic [NREQ-1:0]      flush,
  output fp32_t                div_x1,
  output fp32_t                div_x2,
  input  fp32_t                div_y,
  output logic [NREQ-1:0]      resp_valid,
  output fp32_t                resp_y,
  output logic [TAGW-1:0]      resp_tag,
  output logic                 busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(LAT + 2);

  typedef struct packed {
    logic            v;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
  } slot_t;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_id;
  logic            xfer;
  fp32_t           win_x1;
  fp32_t           win_x2;
  logic [TAGW-1:0] win_tag;
  slot_t           ins;
  logic [CW-1:0]   count;
  logic [CW-1:0]   drop;

  // stage 0 sits beside div_x1/div_x2; stage LAT lines up with div_y
  slot_t           sh [LAT+1];

  assign eligible = req_valid & ~flush;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .id       (gnt_id)
  );

  assign req_ready = rstn ? '0 : grant;
  assign xfer      = |req_ready;

  always_comb begin
    win_x1  = '0;
    win_x2  = '0;
    win_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_x1  = req_x1[32*i +: 32];
        win_x2  = req_x2[32*i +: 32];
        win_tag = req_tag[TAGW*i +: TAGW];
      end
    end
  end

  always_comb begin
    ins     = '0;
    ins.v   = xfer;
    ins.id  = gnt_id;
    ins.tag = win_tag;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ptr    <= '0;
      div_x1 <= '0;
      div_x2 <= '0;
    end else if (xfer) begin
      ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      div_x1 <= win_x1;
      div_x2 <= win_x2;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int k = 0; k <= LAT; k++) sh[k] <= '0;
    end else begin
      sh[0] <= ins;
      for (int k = 1; k <= LAT; k++) begin
        sh[k]   <= sh[k-1];
        sh[k].v <= sh[k-1].v & ~flush[sh[k-1].id];
      end
    end
  end

  // entries leaving this edge: the retiring one plus any flushed
  always_comb begin
    drop = '0;
    for (int k = 0; k <= LAT; k++) begin
      if (sh[k].v && (k == LAT || flush[sh[k].id]))
        drop = drop + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) count <= '0;
    else      count <= count + CW'(xfer) - drop;
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++)
      resp_valid[i] = sh[LAT].v && (sh[LAT].id == IDW'(i)) && !flush[i];
  end

  assign resp_y   = div_y;
  assign resp_tag = sh[LAT].tag;
  assign busy     = (count != '0);

endmodule

// File: tb/tb_fdiv_share_arb.sv
// tb_fdiv_share_arb: directed stimulus with a queue scoreboard for
// results and per-cycle history for latency and masking checks.
module tb_fdiv_share_arb;
  import fdiv_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = 4;
  localparam int TAGW = 5;
  localparam int NV   = 8;

  localparam logic [31:0] VX1 [NV] = '{
    32'h40400000, 32'h40C00000, 32'h3F800000, 32'h41000000,
    32'h41100000, 32'h3F800000, 32'h41200000, 32'h40E00000};
  localparam logic [31:0] VX2 [NV] = '{
    32'h40000000, 32'h40000000, 32'h40000000, 32'h40800000,
    32'h40400000, 32'h40800000, 32'h40800000, 32'h40000000};
  localparam logic [31:0] VQ [NV] = '{
    32'h3FC00000, 32'h40400000, 32'h3F000000, 32'h40000000,
    32'h40400000, 32'h3E800000, 32'h40200000, 32'h40600000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*32-1:0] req_x1 = '0;
  logic [NREQ*32-1:0] req_x2 = '0;
  logic [NREQ*TAGW-1:0] req_tag = '0;
  logic [NREQ-1:0] flush = '0;
  logic [31:0] div_x1, div_x2, div_y, resp_y;
  logic [NREQ-1:0] resp_valid;
  logic [TAGW-1:0] resp_tag;
  logic busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [NREQ-1:0] hist [0:4095];

  typedef struct {
    int id;
    logic [TAGW-1:0] tag;
    logic [31:0] y;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fdiv_share_arb #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .flush(flush),
    .div_x1(div_x1), .div_x2(div_x2), .div_y(div_y),
    .resp_valid(resp_valid), .resp_y(resp_y), .resp_tag(resp_tag),
    .busy(busy));

  // behavioural fdiv: exact quotient lookup, LAT cycles deep
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NV; i++)
      if (VX1[i] == a && VX2[i] == b) return VQ[i];
    return 32'h7FC00000;
  endfunction

  logic [31:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= fmodel(div_x1, div_x2);
    for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
  end
  assign div_y = dpipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_y(input logic [31:0] act, input logic [31:0] exp);
    int d;
    total++;
    d = int'(act) - int'(exp);
    if ($isunknown(act) || d < -4 || d > 4) begin
      bad++;
      $display("FAIL resp_y actual=%h required=%h t=%0t", act, exp, $time);
    end
  endtask

  // monitor: pop on every result, drop flushed owners, push new issues
  always @(negedge clk) begin
    exp_t e;
    hist[cyc] = resp_valid;
    if (rst) begin
      sbq.delete();
    end else begin
      if (resp_valid != '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("resp_owner", 64'(resp_valid), 64'(1) << e.id);
          chk("resp_tag", 64'(resp_tag), 64'(e.tag));
          chk_y(resp_y, e.y);
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (flush[i])
          for (int j = sbq.size() - 1; j >= 0; j--)
            if (sbq[j].id == i) sbq.delete(j);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id  = i;
          e.tag = req_tag[TAGW*i +: TAGW];
          e.y   = fmodel(req_x1[32*i +: 32], req_x2[32*i +: 32]);
          sbq.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int i, input int v, input logic [TAGW-1:0] t);
    req_x1[32*i +: 32] = VX1[v];
    req_x2[32*i +: 32] = VX2[v];
    req_tag[TAGW*i +: TAGW] = t;
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush = '0;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ready"}, 64'(req_ready), 64'(0));
    chk({nm, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({nm, "_busy"}, 64'(busy), 64'(0));
    chk({nm, "_div_x1"}, 64'(div_x1), 64'(0));
    chk({nm, "_div_x2"}, 64'(div_x2), 64'(0));
    chk({nm, "_resp_tag"}, 64'(resp_tag), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog no finish by t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n0;
    set_req(0, 0, 5'd1);
    set_req(1, 1, 5'd2);
    req_valid = 2'b11;
    #1 rst = 1'b1;
    #1 chk_idle_outputs("reset");
    ticks(2);
    req_valid = '0;
    rst = 1'b0;

    // 3.0/2.0, five cycles to resp_valid
    set_req(0, 0, 5'd3);
    req_valid = 2'b01;
    #1 chk("t1_ready", 64'(req_ready), 64'(2'b01));
    tick();
    c0 = cyc;
    req_valid = '0;
    chk("t1_busy", 64'(busy), 64'(1));
    ticks(5);
    for (int k = 0; k < 4; k++) chk("t1_early", 64'(hist[c0+k]), 64'(0));
    chk("t1_latency", 64'(hist[c0+4]), 64'(2'b01));
    chk("t1_idle", 64'(busy), 64'(0));

    // both requesters contend: strict alternation from id 0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_req(0, k % NV, 5'(k));
      set_req(1, (k + 3) % NV, 5'(16 + k));
      req_valid = 2'b11;
      #1 chk("t2_grant", 64'(req_ready), (k % 2 == 0) ? 64'(1) : 64'(2));
      if (k > 0) chk("t2_busy", 64'(busy), 64'(1));
      tick();
    end
    req_valid = '0;
    chk("t2_busy_end", 64'(busy), 64'(1));
    ticks(7);

    // flush requester 1 with three ops of each issued
    do_reset();
    c0 = 0;
    for (int k = 0; k < 6; k++) begin
      set_req(0, (k + 2) % NV, 5'(k));
      set_req(1, (k + 5) % NV, 5'(20 + k));
      req_valid = 2'b11;
      tick();
      if (k == 0) c0 = cyc;
    end
    req_valid = '0;
    flush = 2'b10;
    #1 chk("t3_flush_mask", 64'(resp_valid), 64'(0));
    chk("t3_flush_ready", 64'(req_ready), 64'(0));
    tick();
    flush = '0;
    ticks(2);
    chk("t3_busy_last", 64'(busy), 64'(1));
    tick();
    chk("t3_busy_clear", 64'(busy), 64'(0));
    ticks(3);
    n0 = 0;
    for (int c = c0 + 5; c <= c0 + 11; c++)
      chk("t3_no_req1", 64'(hist[c][1]), 64'(0));
    for (int c = c0; c <= c0 + 11; c++) n0 += int'(hist[c][0]);
    chk("t3_req0_count", 64'(n0), 64'(3));

    // flush[0] with both valid and ptr at 0
    do_reset();
    set_req(0, 6, 5'd9);
    set_req(1, 7, 5'd10);
    req_valid = 2'b11;
    flush = 2'b01;
    #1 chk("t4_skip", 64'(req_ready), 64'(2'b10));
    tick();
    flush = '0;
    set_req(1, 3, 5'd11);
    #1 chk("t4_ptr0", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    ticks(7);

    // requester 1 alone streams eight ops back to back
    c0 = 0;
    for (int k = 0; k < 8; k++) begin
      set_req(1, k, 5'(k));
      req_valid = 2'b10;
      #1 chk("t5_ready", 64'(req_ready), 64'(2'b10));
      tick();
      if (k == 0) c0 = cyc;
    end
    req_valid = '0;
    ticks(6);
    for (int k = 0; k <= 12; k++)
      chk("t5_stream", 64'(hist[c0+k]), (k >= 4 && k < 12) ? 64'(2'b10) : 64'(0));

    // reset mid-flight between edges
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(0, k, 5'(k));
      set_req(1, k + 4, 5'(8 + k));
      req_valid = 2'b11;
      tick();
    end
    #2 rst = 1'b1;
    #1 chk_idle_outputs("t6_async");
    req_valid = '0;
    #3 rst = 1'b0;
    c0 = cyc;
    ticks(11);
    for (int c = c0 + 1; c <= c0 + 10; c++)
      chk("t6_silent", 64'(hist[c]), 64'(0));

    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
